// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC execution/control slice: opcodes, ALU
// function codes, operand-select codes, FSM states and condition-code layout.
package sisc_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FN_W    = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned CC_W    = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OPC_W-1:0] OPC_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ALU_R = 4'h1;
  localparam logic [OPC_W-1:0] OPC_ALU_I = 4'h2;
  localparam logic [OPC_W-1:0] OPC_HLT   = 4'hF;

  localparam logic [FN_W-1:0] FN_ADD = 4'h1;
  localparam logic [FN_W-1:0] FN_SUB = 4'h2;
  localparam logic [FN_W-1:0] FN_NOT = 4'h3;
  localparam logic [FN_W-1:0] FN_OR  = 4'h4;
  localparam logic [FN_W-1:0] FN_AND = 4'h5;
  localparam logic [FN_W-1:0] FN_XOR = 4'h6;
  localparam logic [FN_W-1:0] FN_SHR = 4'h7;
  localparam logic [FN_W-1:0] FN_SHL = 4'h8;

  localparam int unsigned CC_C = 3;
  localparam int unsigned CC_V = 2;
  localparam int unsigned CC_N = 1;
  localparam int unsigned CC_Z = 0;

  typedef enum logic [1:0] {
    ALU_OP_REG = 2'b00,
    ALU_OP_IMM = 2'b01
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_START0    = 3'd0,
    ST_START1    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_HALT      = 3'd7
  } state_t;

  // Instruction word layout; rt overlays the top nibble of imm.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [FN_W-1:0]  mm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/sisc_alu_core.sv
// Combinational 32-bit ALU with C/V/N/Z generation; C and V are only
// meaningful for ADD and SUB and read as zero otherwise.
module sisc_alu_core
  import sisc_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [FN_W-1:0] i_fn,
  output logic [XLEN-1:0] o_result,
  output logic [CC_W-1:0] o_cc
);

  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_sub;
  logic [XLEN-1:0] w_result;
  logic            w_c;
  logic            w_v;

  // SUB is A + ~B + 1 so the carry out means "no borrow".
  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + (XLEN+1)'(1);

  always_comb begin
    w_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (i_fn)
      FN_ADD: begin
        w_result = w_add[XLEN-1:0];
        w_c      = w_add[XLEN];
        w_v      = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_add[XLEN-1] != i_a[XLEN-1]);
      end
      FN_SUB: begin
        w_result = w_sub[XLEN-1:0];
        w_c      = w_sub[XLEN];
        w_v      = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_sub[XLEN-1] != i_a[XLEN-1]);
      end
      FN_NOT:  w_result = ~i_a;
      FN_OR:   w_result = i_a | i_b;
      FN_AND:  w_result = i_a & i_b;
      FN_XOR:  w_result = i_a ^ i_b;
      FN_SHR:  w_result = i_a >> i_b[SHAMT_W-1:0];
      FN_SHL:  w_result = i_a << i_b[SHAMT_W-1:0];
      default: w_result = '0;
    endcase
  end

  assign o_result     = w_result;
  assign o_cc[CC_C]   = w_c;
  assign o_cc[CC_V]   = w_v;
  assign o_cc[CC_N]   = w_result[XLEN-1];
  assign o_cc[CC_Z]   = (w_result == '0);

endmodule

// File: rtl/sisc_exec_ctrl.sv
// SISC execution/control slice: instruction sequencer FSM, ALU instance and
// write-back selector. Control outputs decode directly from state and opcode.
module sisc_exec_ctrl
  import sisc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
)(
  input  logic              clk,
  input  logic              rst_f,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] rsa,
  input  logic [DATA_W-1:0] rsb,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [3:0]        cc,
  output logic              stat_en,
  output logic              rf_we,
  output logic [1:0]        alu_op,
  output logic              wb_sel,
  output logic              rb_sel,
  output logic [DATA_W-1:0] write_data,
  output logic [2:0]        state
);

  instr_t          w_instr;
  state_t          r_state;
  state_t          w_next_state;
  alu_op_t         w_alu_op;
  logic            w_is_alu;
  logic            w_stat_en;
  logic            w_rf_we;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_result;
  logic [CC_W-1:0] w_cc;
  logic            w_wb_sel;
  logic            w_unused;

  assign w_instr  = instr_t'(instruction);
  assign w_is_alu = (w_instr.opcode == OPC_ALU_R) || (w_instr.opcode == OPC_ALU_I);
  // Register specifiers are consumed by the register file, not here.
  assign w_unused = ^{w_instr.rd, w_instr.rs};

  always_ff @(posedge clk) begin
    if (rst_f) r_state <= ST_START0;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stat_en    = 1'b0;
    w_rf_we      = 1'b0;
    w_alu_op     = ALU_OP_REG;
    if (w_instr.opcode == OPC_ALU_I) w_alu_op = ALU_OP_IMM;
    case (r_state)
      ST_START0:    w_next_state = ST_START1;
      ST_START1:    w_next_state = ST_FETCH;
      ST_FETCH:     w_next_state = ST_DECODE;
      ST_DECODE:    w_next_state = (w_instr.opcode == OPC_HLT) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        w_next_state = ST_MEM;
        w_stat_en    = w_is_alu;
      end
      ST_MEM:       w_next_state = ST_WRITEBACK;
      ST_WRITEBACK: begin
        w_next_state = ST_FETCH;
        w_rf_we      = w_is_alu;
      end
      ST_HALT:      w_next_state = ST_HALT;
      default:      w_next_state = ST_START0;
    endcase
  end

  assign w_alu_b = (w_alu_op == ALU_OP_IMM) ? sext_imm(w_instr.imm) : XLEN'(rsb);

  sisc_alu_core u_alu (
    .i_a      (XLEN'(rsa)),
    .i_b      (w_alu_b),
    .i_fn     (w_instr.mm),
    .o_result (w_alu_result),
    .o_cc     (w_cc)
  );

  // Memory write-back is not wired up in this revision.
  assign w_wb_sel = 1'b0;

  assign alu_result = DATA_W'(w_alu_result);
  assign cc         = w_cc;
  assign stat_en    = w_stat_en;
  assign rf_we      = w_rf_we;
  assign alu_op     = w_alu_op;
  assign wb_sel     = w_wb_sel;
  assign rb_sel     = 1'b0;
  assign write_data = w_wb_sel ? mem_data : alu_result;
  assign state      = r_state;

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed and randomized check of sisc_exec_ctrl against an arithmetic
// reference model of the sequencer and ALU.
module tb_sisc_exec_ctrl;

  logic        clk;
  logic        rst_f;
  logic [31:0] instruction;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [31:0] mem_data;
  logic [31:0] alu_result;
  logic [3:0]  cc;
  logic        stat_en;
  logic        rf_we;
  logic [1:0]  alu_op;
  logic        wb_sel;
  logic        rb_sel;
  logic [31:0] write_data;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  sisc_exec_ctrl #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .instruction (instruction),
    .rsa         (rsa),
    .rsb         (rsb),
    .mem_data    (mem_data),
    .alu_result  (alu_result),
    .cc          (cc),
    .stat_en     (stat_en),
    .rf_we       (rf_we),
    .alu_op      (alu_op),
    .wb_sel      (wb_sel),
    .rb_sel      (rb_sel),
    .write_data  (write_data),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: flags from wide unsigned/signed arithmetic.
  function automatic void ref_alu(input logic [3:0] mm, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic [3:0] flags);
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint          s;
    longint          lim;
    logic            c;
    logic            v;
    ua  = 64'(a);
    ub  = 64'(b);
    sa  = $signed(a);
    sb  = $signed(b);
    lim = 64'd2147483647;
    c   = 1'b0;
    v   = 1'b0;
    case (mm)
      4'd1: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb; v = (s > lim) || (s < -lim - 1); end
      4'd2: begin r = a - b; c = (ua >= ub); s = sa - sb; v = (s > lim) || (s < -lim - 1); end
      4'd3: r = ~a;
      4'd4: r = a | b;
      4'd5: r = a & b;
      4'd6: r = a ^ b;
      4'd7: r = a >> b[4:0];
      4'd8: r = a << b[4:0];
      default: r = 32'd0;
    endcase
    flags = {c, v, r[31], r == 32'd0};
  endfunction

  // Applies an instruction at FETCH and checks every cycle through WRITEBACK.
  task automatic do_instr(input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] m);
    int          seq [5];
    logic [3:0]  opc;
    logic        is_alu;
    logic [31:0] bop;
    logic [31:0] er;
    logic [3:0]  ecc;
    seq = '{2, 3, 4, 5, 6};
    instruction = instr; rsa = a; rsb = b; mem_data = m;
    #1;
    opc    = instr[31:28];
    is_alu = (opc == 4'd1) || (opc == 4'd2);
    bop    = (opc == 4'd2) ? {{16{instr[15]}}, instr[15:0]} : b;
    ref_alu(instr[27:24], a, bop, er, ecc);
    for (int k = 0; k < 5; k++) begin
      chk("state",      32'(state),      32'(seq[k]));
      chk("stat_en",    32'(stat_en),    32'(is_alu && k == 2));
      chk("rf_we",      32'(rf_we),      32'(is_alu && k == 4));
      chk("alu_op",     32'(alu_op),     (opc == 4'd2) ? 32'd1 : 32'd0);
      chk("wb_sel",     32'(wb_sel),     32'd0);
      chk("rb_sel",     32'(rb_sel),     32'd0);
      chk("alu_result", alu_result,      er);
      chk("cc",         32'(cc),         32'(ecc));
      chk("write_data", write_data,      er);
      tick();
    end
    chk("back_fetch", 32'(state), 32'd2);
  endtask

  task automatic directed(input string tag, input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_cc);
    instruction = instr; rsa = a; rsb = b; mem_data = 32'hDEAD_BEEF;
    #1;
    chk({tag, "_res"}, alu_result, exp_r);
    chk({tag, "_cc"},  32'(cc),    32'(exp_cc));
    do_instr(instr, a, b, 32'hDEAD_BEEF);
  endtask

  initial begin
    logic [31:0] ri;
    logic [3:0]  ropc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] er;
    logic [3:0]  ecc;

    rst_f = 1'b1; instruction = 32'h0; rsa = 32'h0; rsb = 32'h0; mem_data = 32'h1234_5678;
    tick(); tick();
    chk("rst_state",   32'(state),   32'd0);
    chk("rst_stat_en", 32'(stat_en), 32'd0);
    chk("rst_rf_we",   32'(rf_we),   32'd0);
    rst_f = 1'b0;
    #1;
    chk("start0", 32'(state), 32'd0);
    tick(); chk("start1", 32'(state), 32'd1);
    tick(); chk("fetch1", 32'(state), 32'd2);

    do_instr(32'h0000_0000, 32'h0, 32'h0, 32'h1234_5678);
    directed("add_r", 32'h1131_2000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110);
    directed("sub_eq", 32'h1231_2000, 32'h5, 32'h5, 32'h0, 4'b1001);
    directed("add_i", 32'h2121_FFFF, 32'h3, 32'h0, 32'h2, 4'b1000);
    directed("not0", 32'h1330_0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b0010);
    directed("shl31", 32'h1831_2000, 32'h1, 32'd31, 32'h8000_0000, 4'b0010);
    directed("xor_eq", 32'h1631_2000, 32'h0000_A5A5, 32'h0000_A5A5, 32'h0, 4'b0001);

    // Reset in DECODE aborts the instruction without any enable pulse.
    instruction = 32'h1131_2000; rsa = 32'h1; rsb = 32'h2;
    tick(); chk("abort_decode", 32'(state), 32'd3);
    rst_f = 1'b1;
    tick();
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_se",    32'(stat_en), 32'd0);
    chk("abort_we",    32'(rf_we),   32'd0);
    rst_f = 1'b0;
    tick(); chk("abort_s1", 32'(state), 32'd1); chk("abort_se1", 32'(stat_en), 32'd0);
    tick(); chk("abort_f",  32'(state), 32'd2); chk("abort_we1", 32'(rf_we),   32'd0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       ropc = 4'd0;
        1:       ropc = 4'd1;
        2:       ropc = 4'd2;
        default: ropc = 4'($urandom_range(3, 14));
      endcase
      ri = $urandom;
      ri[31:28] = ropc;
      if ($urandom_range(0, 3) == 0) ri[27:24] = 4'($urandom_range(1, 2));
      case ($urandom_range(0, 3))
        0:       begin ra = 32'h7FFF_FFFF; rb = 32'($urandom_range(0, 3)); end
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      do_instr(ri, ra, rb, $urandom);
    end

    // Halt: sequence stalls in HALT with no enables until reset.
    instruction = 32'hF000_0000; rsa = $urandom; rsb = $urandom; mem_data = ~rsa;
    #1;
    ref_alu(4'd0, rsa, rsb, er, ecc);
    chk("hlt_fetch", 32'(state), 32'd2);
    tick(); chk("hlt_decode", 32'(state), 32'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hlt_state", 32'(state),   32'd7);
      chk("hlt_se",    32'(stat_en), 32'd0);
      chk("hlt_we",    32'(rf_we),   32'd0);
      chk("hlt_wd",    write_data,   er);
      chk("hlt_cc",    32'(cc),      32'(ecc));
    end
    rst_f = 1'b1;
    tick(); chk("hlt_rst", 32'(state), 32'd0);
    rst_f = 1'b0;
    tick(); chk("hlt_s1", 32'(state), 32'd1);
    tick(); chk("hlt_f",  32'(state), 32'd2);
    do_instr(32'h1431_2000, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sisc_exec_ctrl.md
Name: sisc_exec_ctrl

Overview:
- Execution and control slice of the SISC processor: instruction sequencer (control FSM), 32-bit ALU with condition codes, and write-back data selector.
- Sits between the register file (supplies rsa/rsb, consumes write_data/rf_we), the status register (consumes cc/stat_en) and the read-port-B mux (consumes rb_sel).
- The instruction word is supplied externally and held stable for a full FETCH..WRITEBACK sequence.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_f  in  1  synchronous, active-high reset
- instruction  in  32  [31:28] opcode, [27:24] mm/function, [23:20] rd, [19:16] rs, [15:12] rt, [15:0] imm
- rsa  in  32  register file port A data
- rsb  in  32  register file port B data
- mem_data  in  32  alternate write-back source
- alu_result  out  32  combinational ALU result
- cc  out  4  condition codes: [3] C, [2] V, [1] N, [0] Z
- stat_en  out  1  status register load enable
- rf_we  out  1  register file write enable
- alu_op  out  2  00 register operand, 01 immediate operand, 10/11 unused
- wb_sel  out  1  0 selects alu_result, 1 selects mem_data
- rb_sel  out  1  0 selects rt, 1 selects rd, for read port B
- write_data  out  32  wb_sel ? mem_data : alu_result
- state  out  3  current FSM state, for debug

Behaviour:
- FSM states and encodings:
  - START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- Reset:
  - rst_f high at a rising edge sets state to START0.
  - A reset asserted mid-instruction aborts that instruction; no rf_we or stat_en pulse follows.
- Transitions:
  - START0 -> START1 -> FETCH -> DECODE.
  - DECODE -> HALT if opcode = 1111, otherwise -> EXECUTE.
  - EXECUTE -> MEM -> WRITEBACK -> FETCH.
  - HALT is held until reset.
- Opcodes:
  - 0000 NOP.
  - 0001 ALU, register operand.
  - 0010 ALU, immediate operand.
  - 1111 HLT.
  - All others behave as NOP: they pass through all states but assert no enables.
- Outputs are combinational from state and opcode:
  - stat_en = 1 only in EXECUTE with opcode 0001/0010.
  - rf_we = 1 only in WRITEBACK with opcode 0001/0010.
  - alu_op = 01 when opcode = 0010, otherwise 00; driven in every state.
  - wb_sel = 0 and rb_sel = 0 in all states in this revision.
- ALU operands:
  - A = rsa.
  - B = rsb when alu_op = 00; B = sign-extended imm[15:0] when alu_op = 01.
- ALU functions, selected by mm:
  - 0001 ADD: A+B.
  - 0010 SUB: A-B.
  - 0011 NOT: ~A, B ignored.
  - 0100 OR.
  - 0101 AND.
  - 0110 XOR.
  - 0111 SHR: A >> B[4:0], logical.
  - 1000 SHL: A << B[4:0].
  - Any other mm: result 0.
- Condition codes:
  - Z = (result == 0).
  - N = result[31].
  - ADD: C = carry out of bit 31; V = signed overflow.
  - SUB: computed as A + ~B + 1; C = carry out, so 1 means no borrow; V = signed overflow.
  - All other functions: C = 0, V = 0.
- ALU and mux are purely combinational; alu_result, cc and write_data follow their inputs in the same cycle.
- Per-instruction latency is 5 cycles, FETCH through WRITEBACK. The first FETCH is the 3rd cycle after reset release.

Decomposition:
- sisc_pkg holds:
  - opcode constants (NOP, ALU_R, ALU_I, HLT);
  - function codes;
  - alu_op codes;
  - state typedef and encodings;
  - cc bit indices.
- One sub-module is natural: sisc_alu_core, the combinational ALU with cc generation.
- The FSM and the write-back mux stay in the top module.

Test Plan:
- Reset and sequencing: hold rst_f high 2 cycles, then release.
  - state sequence must be 0,1,2,3,4,5,6,2.
  - rf_we and stat_en are low throughout when instruction = 0x00000000.
- ADD, register operand: instruction = 0x11312000, rsa = 0x7FFFFFFF, rsb = 0x00000001.
  - alu_result = 0x80000000; cc = 0110 (V, N).
  - stat_en high only in EXECUTE; rf_we high only in WRITEBACK.
  - write_data = 0x80000000.
- SUB equal operands: mm = 0010, rsa = rsb = 0x00000005.
  - alu_result = 0; cc = 1001 (C, Z).
- Immediate ADD with negative imm: instruction = 0x2121FFFF, rsa = 0x00000003.
  - alu_op = 01; alu_result = 0x00000002; cc = 1000.
- Logic and shift: NOT with rsa = 0 -> 0xFFFFFFFF, cc = 0010.
  - SHL with rsa = 1, rsb = 31 -> 0x80000000, cc = 0010.
  - XOR with equal operands -> cc = 0001.
- HLT and mux: instruction = 0xF0000000 -> state reaches 7 after DECODE and stays there.
  - No rf_we or stat_en pulse.
  - Asserting rst_f returns state to 0.
  - Forcing wb_sel is not possible; write_data must equal alu_result in every state.
